// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch port.
package imem_pkg;

  localparam int XLEN    = 64;
  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    IMEM_OK       = 2'b00,
    IMEM_MISALIGN = 2'b01,
    IMEM_RANGE    = 2'b10,
    IMEM_PARITY   = 2'b11
  } imem_err_e;

  // Misalignment outranks range, which outranks a parity hit.
  function automatic imem_err_e imem_err_decode(input logic misalign,
                                                input logic range_bad,
                                                input logic parity_bad);
    if (misalign)   return IMEM_MISALIGN;
    if (range_bad)  return IMEM_RANGE;
    if (parity_bad) return IMEM_PARITY;
    return IMEM_OK;
  endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Synchronous response FIFO with synchronous clear; head is shown combinationally.
module imem_rsp_fifo
  import imem_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = logic [7:0],
  parameter int  CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  output entry_t           head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t             store [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop_ok)
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Payload storage needs no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push_ok)
      store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/imem_fetch_port.sv
// Pipelined multi-word instruction fetch port with in-order response queue and flush.
// Optional per-word even parity storage/check is enabled by defining IMEM_PARITY_EN.
module imem_fetch_port
  import imem_pkg::*;
#(
  parameter int    DEPTH     = 1024,
  parameter int    FETCH_W   = 1,
  parameter int    LATENCY   = 1,
  parameter string INIT_FILE = ""
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [XLEN-1:0]            req_addr,
  input  logic                       flush,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [XLEN-1:0]            rsp_addr,
  output logic [INSTR_W*FETCH_W-1:0] rsp_instr,
  output logic [1:0]                 rsp_err
);

  localparam int AW    = $clog2(DEPTH);
  localparam int QD    = LATENCY + 1;
  localparam int CNT_W = $clog2(LATENCY + 2);
  localparam int FCW   = $clog2(QD + 1);
`ifdef IMEM_PARITY_EN
  localparam int MEM_W = INSTR_W + 1;
`else
  localparam int MEM_W = INSTR_W;
`endif

  typedef struct packed {
    logic [XLEN-1:0]            addr;
    logic [INSTR_W*FETCH_W-1:0] instr;
    imem_err_e                  err;
  } imem_rsp_t;

  logic [MEM_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             pop;
  logic             misalign;
  logic             range_bad;
  logic             parity_bad;
  logic [XLEN-2:0]  last_word;
  logic [AW-1:0]    word_idx;
  imem_rsp_t        beat;
  logic             push;
  imem_rsp_t        push_data;
  imem_rsp_t        head;
  logic [FCW-1:0]   fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             unused_fifo;

  // Read-only image: zero fill, then parity generation.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
`ifdef IMEM_PARITY_EN
    for (int i = 0; i < DEPTH; i++) mem[i][INSTR_W] = ^mem[i][INSTR_W-1:0];
`endif
  end

  assign req_ready = !rst && !flush && (cnt < CNT_W'(QD));
  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  // Range check uses the full word index, so far addresses never alias into memory.
  assign misalign  = (req_addr[1:0] != 2'b00);
  assign last_word = {1'b0, req_addr[XLEN-1:2]} + (XLEN-1)'(FETCH_W - 1);
  assign range_bad = (last_word >= (XLEN-1)'(DEPTH));
  assign word_idx  = req_addr[AW+1:2];

  always_comb begin
    beat       = '0;
    parity_bad = 1'b0;
    beat.addr  = req_addr;
    for (int i = 0; i < FETCH_W; i++) begin
      beat.instr[INSTR_W*i +: INSTR_W] = mem[word_idx + AW'(i)][INSTR_W-1:0];
`ifdef IMEM_PARITY_EN
      parity_bad = parity_bad | (^mem[word_idx + AW'(i)]);
`endif
    end
    if (misalign || range_bad)
      beat.instr = '0;
    beat.err = imem_err_decode(misalign, range_bad, parity_bad);
  end

  // The accept cycle counts as the first stage; LATENCY-1 registers follow before the queue.
  generate
    if (LATENCY == 1) begin : g_direct
      assign push      = accept;
      assign push_data = beat;
    end else begin : g_pipe
      logic [LATENCY-2:0] pv_q;
      imem_rsp_t          pd_q [LATENCY-1];

      always_ff @(posedge clk) begin
        if (rst || flush) begin
          pv_q <= '0;
        end else begin
          pv_q[0] <= accept;
          for (int i = 1; i < LATENCY - 1; i++) pv_q[i] <= pv_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        pd_q[0] <= beat;
        for (int i = 1; i < LATENCY - 1; i++) pd_q[i] <= pd_q[i-1];
      end

      assign push      = pv_q[LATENCY-2];
      assign push_data = pd_q[LATENCY-2];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || flush)
      cnt <= '0;
    else
      cnt <= cnt + CNT_W'(accept) - CNT_W'(pop);
  end

  imem_rsp_fifo #(
    .DEPTH   (QD),
    .entry_t (imem_rsp_t),
    .CNT_W   (FCW)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign unused_fifo = ^{fifo_count, fifo_full};

  assign rsp_valid = !fifo_empty;
  assign rsp_addr  = fifo_empty ? '0 : head.addr;
  assign rsp_instr = fifo_empty ? '0 : head.instr;
  assign rsp_err   = fifo_empty ? 2'b00 : head.err;

endmodule
